text_pixel_serializer: RTL

- Pixel back-end stage directly downstream of the text dispatch/RAM stage.
- Consumes the per-cell ASCIIColChar attribute word and GlyphWord font data, plus the shared PixelCount/LineCount/SubPixelCount timing.
- Serialises the glyph row MSB-first at the pixel rate (one pixel per 4 clk), applies foreground/background palette and attribute blink, and drives registered RGB332 colour to the DAC/pin stage.
- Sync pulses are generated elsewhere; this block produces colour and a valid flag only.

---
 rtl/text_pixel_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/text_pixel_serializer.sv
// text_pixel_serializer
//   Pixel back-end for the text display path. Once per 8-pixel character
//   cell it latches one glyph row and the cell attributes. It then shifts
//   the row out MSB-first, one pixel every 4 clk. Each pixel bit picks the
//   foreground or background palette entry. Attribute blink can hide the
//   foreground. The result is driven as a registered RGB332 colour.
//
// Ports
//   clk            system clock, 4 clk per pixel
//   reset          synchronous, active-high
//   SubPixelCount  clk phase within the current pixel (0..3)
//   PixelCount     current pixel column (0..799)
//   LineCount      current line (0..524)
//   ASCIIColChar   attribute word: [15] blink, [14:12] bg, [11:8] fg, [7:0] code
//   GlyphWord      font word: [15:8] even-line row, [7:0] odd-line row
//   Red/Green/Blue registered RGB332 colour, 0 outside the active area
//   PixelValid     registered; high while the displayed pixel is in the active area
//
// Output qualification: there is no handshake. Red/Green/Blue are meaningful
// only in cycles where PixelValid is 1, and they are forced to 0 otherwise.
module text_pixel_serializer #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  SubPixelCount,
  input  logic [9:0]  PixelCount,
  input  logic [9:0]  LineCount,
  input  logic [15:0] ASCIIColChar,
  input  logic [15:0] GlyphWord,
  output logic [2:0]  Red,
  output logic [2:0]  Green,
  output logic [1:0]  Blue,
  output logic        PixelValid
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [9:0] H_LIMIT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIMIT    = 10'(V_ACTIVE);

  logic [7:0] shreg;
  logic [3:0] fg;
  logic [2:0] bg;
  logic       blink_en;
  logic [7:0] frame_cnt;
  logic       blink_phase;

  logic       ld;
  logic       sh;
  logic       act;
  logic       frame_start;
  logic [7:0] glyph_row;
  logic [3:0] col_idx;
  logic [7:0] rgb;

  // The last clk of pixel 7 of every cell loads the next cell, so the next
  // pixel slot (column 0 of that cell) already sees the new MSB.
  assign ld          = (SubPixelCount == 2'd3) && (PixelCount[2:0] == 3'd7);
  assign sh          = (SubPixelCount == 2'd3) && !ld;
  assign act         = (PixelCount < H_LIMIT) && (LineCount < V_LIMIT);
  assign frame_start = (PixelCount == 10'd0) && (LineCount == 10'd0) &&
                       (SubPixelCount == 2'd0);
  assign glyph_row   = LineCount[0] ? GlyphWord[7:0] : GlyphWord[15:8];

  // Colour index for the pixel currently at the shift register MSB. During
  // the hidden blink half-period the foreground is replaced by the
  // background, so the whole cell shows the background.
  always_comb begin
    col_idx = {1'b0, bg};
    if (shreg[7] && !(blink_en && blink_phase)) begin
      col_idx = fg;
    end
  end

  always_comb begin
    rgb = 8'h00;
    case (col_idx)
      4'd0:    rgb = 8'h00;
      4'd1:    rgb = 8'h02;
      4'd2:    rgb = 8'h14;
      4'd3:    rgb = 8'h16;
      4'd4:    rgb = 8'hA0;
      4'd5:    rgb = 8'hA2;
      4'd6:    rgb = 8'hA8;
      4'd7:    rgb = 8'hB6;
      4'd8:    rgb = 8'h49;
      4'd9:    rgb = 8'h4B;
      4'd10:   rgb = 8'h5D;
      4'd11:   rgb = 8'h5F;
      4'd12:   rgb = 8'hE9;
      4'd13:   rgb = 8'hEB;
      4'd14:   rgb = 8'hFD;
      default: rgb = 8'hFF;
    endcase
  end

  // Glyph shifter and cell attribute latches. A load takes priority over a
  // shift, so no bit of the old cell leaks into the new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= 8'h00;
      fg       <= 4'h0;
      bg       <= 3'h0;
      blink_en <= 1'b0;
    end else if (ld) begin
      shreg    <= glyph_row;
      fg       <= ASCIIColChar[11:8];
      bg       <= ASCIIColChar[14:12];
      blink_en <= ASCIIColChar[15];
    end else if (sh) begin
      shreg    <= {shreg[6:0], 1'b0};
    end
  end

  // Frame counter for attribute blink. The phase flips every BLINK_FRAMES
  // frames, so a full blink period is 2*BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= 8'h00;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt   <= 8'h00;
        blink_phase <= !blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + 8'h01;
      end
    end
  end

  // Registered colour output with one clk of latency from the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      Red        <= 3'h0;
      Green      <= 3'h0;
      Blue       <= 2'h0;
      PixelValid <= 1'b0;
    end else begin
      {Red, Green, Blue} <= act ? rgb : 8'h00;
      PixelValid         <= act;
    end
  end

endmodule
